input_ctrl: RTL
===============

# input_ctrl

User-input front end for the matrix calculator: synchronizes and debounces the confirm/back push-buttons, samples the 8 slide switches, and runs the mode/operation selection FSM. It drives `main_state`, `sub_state`, `op_type` and `error_code` to `display_ctrl` and the core. It also emits switch-entered bytes to matrix storage or the compute engine over a valid/ready handshake.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required to accept a button level (10 ms at 100 MHz); bench uses 4.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  reset, asynchronous, active-low
- btn_confirm  in  1  raw confirm button, active-high, asynchronous to clk
- btn_back  in  1  raw back button, active-high, asynchronous to clk
- sw  in  8  raw slide switches, asynchronous to clk
- main_state  out  3  0 Menu, 1 Input, 2 Generate, 3 Display, 4 Compute, 5 Setting
- sub_state  out  4  per-mode sub-state (see Operation)
- op_type  out  4  1 Transpose, 2 Add, 3 Scalar, 4 Mult, 5 Conv, 0 none
- error_code  out  4  0 none, 1 bad mode, 2 value out of range, 3 bad op
- data_out  out  8  entered byte
- data_valid  out  1  data_out valid
- data_ready  in  1  consumer accepts data_out

## Operation
- **Input conditioning:**
  - Each button and all 8 switch bits pass through a 2-FF synchronizer.
  - Each button then has a debounce counter. It clears whenever the synchronized sample differs from the debounced level. When it reaches DEBOUNCE_CYCLES-1 with a differing sample, the debounced level takes the sample.
  - A 0→1 transition of the debounced level produces a one-cycle pulse (`cfm_p`, `back_p`). Release produces nothing.
- **FSM on `main_state`:**
  - **Menu (0):**
    - `cfm_p` with `sw_s[2:0]` in 1..5 sets `main_state` to that value, `sub_state`=0, `error_code`=0.
    - `cfm_p` with any other value sets `error_code`=1 and stays in Menu.
  - **Input (1):**
    - `cfm_p` with `sw_s` ≤ 9 loads `data_out`=`sw_s`, raises `data_valid`, sets `sub_state`=1 (busy), and clears `error_code`.
    - `cfm_p` with `sw_s` > 9 sets `error_code`=2; nothing is emitted.
  - **Generate (2), Display (3), Setting (5):** `cfm_p` emits `data_out`=`sw_s` unchecked, with `sub_state`=1 while pending.
  - **Compute (4):**
    - `sub_state` 0: `cfm_p` with `sw_s[2:0]` in 1..5 sets `op_type`=`sw_s[2:0]` and `sub_state`=2. Otherwise `error_code`=3.
    - `sub_state` 2: `cfm_p` emits `data_out`={4'h0, `op_type`} as the start command and sets `sub_state`=3. On acceptance it returns to `sub_state`=2.
- **Handshake:**
  - Transfer occurs in a cycle with `data_valid`&&`data_ready`. `data_valid` drops the next cycle and `sub_state` returns to its pre-emit value (0 or 2).
  - While `data_valid`=1, `data_out` is stable and further `cfm_p` pulses are ignored.
- **Back:**
  - `back_p` in Compute with `sub_state` 2 returns to `sub_state` 0 and clears `op_type`.
  - `back_p` anywhere else goes to Menu and clears `sub_state`, `op_type` and `error_code`.
  - In all cases `back_p` clears `data_valid`. An unaccepted byte is withdrawn; consumers must tolerate this.
  - In Menu, `back_p` clears `error_code` only.
- **Error clearing:** `error_code` persists until the next successful confirm or a back.

## Timing
- **Reset:**
  - `main_state`=0, `sub_state`=0, `op_type`=0, `error_code`=0, `data_out`=0, `data_valid`=0.
  - Synchronizers, debounced levels and counters all clear to 0.
  - A button held through reset release registers one press after debounce.
- **Button latency:** a raw 0→1 that stays stable gives `cfm_p`/`back_p` high exactly DEBOUNCE_CYCLES+3 clk edges after the first edge sampling it high. All FSM outputs update on the following edge.
- **Glitch rejection:** a raw pulse shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- **Switches:** FSM uses `sw_s`, 2 cycles behind `sw`.
- **Emit timing:** `data_valid` rises 1 cycle after `cfm_p`. If `data_ready` is already high, transfer happens in that cycle and `data_valid` is 0 the cycle after.
- **Simultaneous pulses:** `back_p` and `cfm_p` in the same cycle resolve to back only.
- **Registered outputs:** all outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert rst_n=0 mid-operation with `data_valid`=1 → all outputs 0 asynchronously; after release `main_state`=0.
- **Debounce** (DEBOUNCE_CYCLES=4): glitch `btn_confirm` high for 3 cycles → no state change. Hold it high with `sw`=8'h04 → `main_state`=4 exactly 8 edges after the first high sample.
- **Menu errors:** `sw`=8'h07 then confirm → `error_code`=1 and `main_state`=0. Then `sw`=8'h01 and confirm → `main_state`=1, `error_code`=0.
- **Input handshake:**
  - `sw`=8'h07, confirm, `data_ready`=0 for 5 cycles → `data_out`=7, `data_valid`=1, `sub_state`=1 held.
  - A second confirm during the stall is ignored.
  - `data_ready`=1 → one transfer, then `data_valid`=0 and `sub_state`=0.
  - `sw`=8'h0A then confirm → `error_code`=2, no valid.
- **Compute:**
  - In mode 4, `sw`=8'h03 then confirm → `op_type`=3, `sub_state`=2.
  - Confirm again → `data_out`=8'h03 and `sub_state`=3 until ready.
  - Back → `sub_state`=0, `op_type`=0.
  - Back again → `main_state`=0.
- **Simultaneous buttons:** press both buttons in the same cycle in Input with pending data → goes to Menu, `data_valid`=0, nothing emitted.

Source files
------------

// File: rtl/input_ctrl.sv
// rtl/input_ctrl.sv - button/switch conditioning and mode/operation selection FSM
module input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_confirm,
    input  logic       btn_back,
    input  logic [7:0] sw,
    output logic [2:0] main_state,
    output logic [3:0] sub_state,
    output logic [3:0] op_type,
    output logic [3:0] error_code,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        M_MENU     = 3'd0,
        M_INPUT    = 3'd1,
        M_GENERATE = 3'd2,
        M_DISPLAY  = 3'd3,
        M_COMPUTE  = 3'd4,
        M_SETTING  = 3'd5
    } mode_t;

    // bit 0 = confirm, bit 1 = back
    logic [1:0]         btn_m, btn_s, lvl, lvl_d, pulse;
    logic [1:0][CW-1:0] cnt;
    logic [7:0]         sw_m, sw_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m <= '0;
            btn_s <= '0;
            sw_m  <= '0;
            sw_s  <= '0;
            lvl   <= '0;
            lvl_d <= '0;
            pulse <= '0;
            cnt   <= '0;
        end else begin
            btn_m <= {btn_back, btn_confirm};
            btn_s <= btn_m;
            sw_m  <= sw;
            sw_s  <= sw_m;
            lvl_d <= lvl;
            pulse <= lvl & ~lvl_d;
            for (int i = 0; i < 2; i++) begin
                if (btn_s[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    lvl[i] <= btn_s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic cfm_p, back_p;
    assign cfm_p  = pulse[0];
    assign back_p = pulse[1];

    mode_t      mode_q, mode_n;
    logic [3:0] sub_q, sub_n, op_q, op_n, err_q, err_n;
    logic [7:0] dout_q, dout_n;
    logic       valid_q, valid_n;
    logic       sel_ok;

    assign sel_ok = (sw_s[2:0] >= 3'd1) && (sw_s[2:0] <= 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= M_MENU;
            sub_q   <= '0;
            op_q    <= '0;
            err_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            mode_q  <= mode_n;
            sub_q   <= sub_n;
            op_q    <= op_n;
            err_q   <= err_n;
            dout_q  <= dout_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        mode_n  = mode_q;
        sub_n   = sub_q;
        op_n    = op_q;
        err_n   = err_q;
        dout_n  = dout_q;
        valid_n = valid_q;
        if (back_p) begin
            // back wins over a simultaneous confirm and withdraws any pending byte
            valid_n = 1'b0;
            if (mode_q == M_COMPUTE && sub_q == 4'd2) begin
                sub_n = 4'd0;
                op_n  = 4'd0;
            end else begin
                mode_n = M_MENU;
                sub_n  = 4'd0;
                op_n   = 4'd0;
                err_n  = 4'd0;
            end
        end else if (valid_q) begin
            if (data_ready) begin
                valid_n = 1'b0;
                sub_n   = (mode_q == M_COMPUTE) ? 4'd2 : 4'd0;
            end
        end else if (cfm_p) begin
            case (mode_q)
                M_MENU: begin
                    if (sel_ok) begin
                        mode_n = mode_t'(sw_s[2:0]);
                        sub_n  = 4'd0;
                        err_n  = 4'd0;
                    end else begin
                        err_n = 4'd1;
                    end
                end
                M_INPUT: begin
                    if (sw_s <= 8'd9) begin
                        dout_n  = sw_s;
                        valid_n = 1'b1;
                        sub_n   = 4'd1;
                        err_n   = 4'd0;
                    end else begin
                        err_n = 4'd2;
                    end
                end
                M_GENERATE, M_DISPLAY, M_SETTING: begin
                    dout_n  = sw_s;
                    valid_n = 1'b1;
                    sub_n   = 4'd1;
                    err_n   = 4'd0;
                end
                M_COMPUTE: begin
                    if (sub_q == 4'd0) begin
                        if (sel_ok) begin
                            op_n  = {1'b0, sw_s[2:0]};
                            sub_n = 4'd2;
                            err_n = 4'd0;
                        end else begin
                            err_n = 4'd3;
                        end
                    end else if (sub_q == 4'd2) begin
                        dout_n  = {4'h0, op_q};
                        valid_n = 1'b1;
                        sub_n   = 4'd3;
                        err_n   = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign main_state = mode_q;
    assign sub_state  = sub_q;
    assign op_type    = op_q;
    assign error_code = err_q;
    assign data_out   = dout_q;
    assign data_valid = valid_q;

endmodule
